shift_unit_seq: RTL and testbench

Parametrised sequential shift/rotate unit, successor to the combinational 4-bit shift operator. Accepts an operand, op code and shift amount over a valid/ready handshake. Performs one bit-step per clock and returns the result with a valid/ready handshake. Used wherever a datapath needs area-cheap multi-bit shifts, rotates or serial-fill shifts of arbitrary width.

---
 rtl/shift_unit_seq_if.sv | 28 ++
 rtl/shift_unit_seq.sv | 106 ++++++++++
 tb/tb_shift_unit_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for the sequential shift unit.
// The master issues requests and consumes results; the slave is the unit itself.
interface shift_unit_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] amount;
  logic [WIDTH-1:0]   data_in;
  logic               ser_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic               ser_out;
  logic               busy;

  modport master (
    output in_valid, op, amount, data_in, ser_in, out_ready,
    input  in_ready, out_valid, data_out, ser_out, busy
  );

  modport slave (
    input  in_valid, op, amount, data_in, ser_in, out_ready,
    output in_ready, out_valid, data_out, ser_out, busy
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: one bit-step per clock over a latched op,
// with valid/ready on both the request and the result side.
module shift_unit_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  shift_unit_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_SAR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_SHLS = 3'b110,
    OP_SHRS = 3'b111
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               ser_q, ser_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [SHAMT_W-1:0] eff_amount;
  logic [WIDTH-1:0]   step_data;
  logic               step_ser;

  // PASS never shifts, whatever amount arrives with it.
  assign eff_amount = (op_e'(bus.op) == OP_PASS) ? '0 : bus.amount;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    step_data = data_q;
    step_ser  = 1'b0;
    case (op_q)
      OP_SHL:  begin step_data = {data_q[WIDTH-2:0], 1'b0};          step_ser = data_q[WIDTH-1]; end
      OP_SHR:  begin step_data = {1'b0, data_q[WIDTH-1:1]};          step_ser = data_q[0];       end
      OP_SAR:  begin step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]}; step_ser = data_q[0];     end
      OP_ROL:  begin step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; step_ser = data_q[WIDTH-1]; end
      OP_ROR:  begin step_data = {data_q[0], data_q[WIDTH-1:1]};     step_ser = data_q[0];       end
      OP_SHLS: begin step_data = {data_q[WIDTH-2:0], bus.ser_in};    step_ser = data_q[WIDTH-1]; end
      OP_SHRS: begin step_data = {bus.ser_in, data_q[WIDTH-1:1]};    step_ser = data_q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = op_e'(bus.op);
          data_d  = bus.data_in;
          ser_d   = 1'b0;
          cnt_d   = eff_amount;
          state_d = (eff_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step_data;
        ser_d  = step_ser;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_PASS;
      data_q  <= '0;
      ser_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.data_out  = data_q;
  assign bus.ser_out   = ser_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_shift_unit_seq;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ser;
    int               eff;
    int               acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  bit   bp_hold = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_unit_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_unit_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: closed-form result of applying the op 'amt' times; s[k] is the fill bit of step k.
  function automatic logic [WIDTH:0] model(input logic [2:0] op, input int amt,
                                           input logic [WIDTH-1:0] d, input logic [15:0] s);
    logic [63:0]      w;
    logic [WIDTH-1:0] r;
    logic             so;
    int               rot;
    if (op == 3'b000) amt = 0;
    rot = amt % WIDTH;
    w   = 64'(d);
    r   = d;
    so  = 1'b0;
    case (op)
      3'b001: begin w = 64'(d) << amt; r = w[WIDTH-1:0]; so = w[WIDTH]; end
      3'b010: begin so = (amt > 0) ? w[amt-1] : 1'b0; w = w >> amt; r = w[WIDTH-1:0]; end
      3'b011: begin
        w  = {{(64-WIDTH){d[WIDTH-1]}}, d};
        so = (amt > 0) ? w[amt-1] : 1'b0;
        w  = w >> amt;
        r  = w[WIDTH-1:0];
      end
      3'b100: begin w = (64'(d) << rot) | (64'(d) >> (WIDTH - rot)); r = w[WIDTH-1:0]; so = (amt > 0) ? r[0] : 1'b0; end
      3'b101: begin w = (64'(d) >> rot) | (64'(d) << (WIDTH - rot)); r = w[WIDTH-1:0]; so = (amt > 0) ? r[WIDTH-1] : 1'b0; end
      3'b110: begin
        w = 64'(d) << amt;
        for (int k = 0; k < amt; k++) w[amt-1-k] = s[k];
        r  = w[WIDTH-1:0];
        so = w[WIDTH];
      end
      3'b111: begin
        for (int k = 0; k < amt; k++) w[WIDTH+k] = s[k];
        so = (amt > 0) ? w[amt-1] : 1'b0;
        w  = w >> amt;
        r  = w[WIDTH-1:0];
      end
      default: ;
    endcase
    return {so, r};
  endfunction

  // out_ready driver: always-ready, random, or held low for backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = bp_hold ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  // Monitor: latency and busy length on the rising edge of out_valid, data on handshake.
  initial begin
    exp_t cur;
    int   busy_cnt = 0;
    bit   prev_valid = 1'b0;
    bit   ready_next = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt   = 0;
        prev_valid = 1'b0;
        ready_next = 1'b0;
      end else begin
        if (ready_next) check("in_ready_after_done", bus.in_ready, 1);
        ready_next = 1'b0;
        if (bus.busy) busy_cnt++;
        if (bus.out_valid && !prev_valid) begin
          if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
          else begin
            cur = sb[0];
            check("latency", cyc - cur.acc_cyc, cur.eff);
            check("busy_cycles", busy_cnt, cur.eff);
            check("in_ready_in_done", bus.in_ready, 0);
          end
        end
        if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
          cur = sb.pop_front();
          check("data_out", bus.data_out, cur.data);
          check("ser_out", bus.ser_out, cur.ser);
          busy_cnt   = 0;
          ready_next = 1'b1;
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int waited = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!bus.in_ready) begin
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", 0, 1);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [2:0] op, input int amt, input logic [WIDTH-1:0] d,
                      input logic [15:0] s, input logic [WIDTH-1:0] ed, input logic es);
    exp_t e;
    bit   ok;
    int   eff;
    eff = (op == 3'b000) ? 0 : amt;
    wait_ready(ok);
    if (!ok) return;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.amount   = SHAMT_W'(amt);
    bus.data_in  = d;
    @(posedge clk); #1;
    e.data = ed; e.ser = es; e.eff = eff; e.acc_cyc = cyc;
    sb.push_back(e);
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.amount   = SHAMT_W'($urandom);
    bus.data_in  = WIDTH'($urandom);
    for (int k = 0; k < eff; k++) begin
      bus.ser_in = s[k];
      @(posedge clk); #1;
    end
    bus.ser_in = 1'($urandom);
  endtask

  task automatic send_rand();
    logic [2:0]       op;
    int               amt;
    logic [WIDTH-1:0] d;
    logic [15:0]      s;
    logic [WIDTH:0]   m;
    op  = 3'($urandom);
    amt = $urandom_range((1 << SHAMT_W) - 1);
    d   = WIDTH'($urandom);
    s   = 16'($urandom);
    m   = model(op, amt, d, s);
    send(op, amt, d, s, m[WIDTH-1:0], m[WIDTH]);
    repeat ($urandom_range(2)) @(posedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] held_data;
    logic             held_ser;
    bit               ok;
    int               waited;

    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.amount   = '0;
    bus.data_in  = '0;
    bus.ser_in   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_ser_out", bus.ser_out, 0);

    // Directed cases with hand-derived results.
    send(3'b001, 1,  8'h81, 16'h0000, 8'h02, 1'b1);
    send(3'b011, 3,  8'h90, 16'h0000, 8'hF2, 1'b0);
    send(3'b010, 3,  8'h90, 16'h0000, 8'h12, 1'b0);
    send(3'b101, 9,  8'h01, 16'h0000, 8'h80, 1'b1);
    send(3'b001, 15, 8'hFF, 16'h0000, 8'h00, 1'b0);
    send(3'b000, 7,  8'hA5, 16'h0000, 8'hA5, 1'b0);
    send(3'b110, 3,  8'h00, 16'h0007, 8'h07, 1'b0);
    send(3'b111, 2,  8'hFF, 16'h0000, 8'h3F, 1'b1);
    send(3'b100, 10, 8'h81, 16'h0000, 8'h06, 1'b0);
    send(3'b011, 12, 8'h80, 16'h0000, 8'hFF, 1'b1);

    // Backpressure: result must hold while in_valid toggles data_in.
    bp_hold = 1'b1;
    send(3'b001, 1, 8'h81, 16'h0000, 8'h02, 1'b1);
    waited = 0;
    while (!bus.out_valid && waited < 50) begin @(negedge clk); waited++; end
    check("bp_reached_done", bus.out_valid, 1);
    held_data = bus.data_out;
    held_ser  = bus.ser_out;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = 3'b001;
      bus.amount   = SHAMT_W'(2);
      bus.data_in  = WIDTH'($urandom);
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_data_hold", bus.data_out, held_data);
      check("bp_ser_hold", bus.ser_out, held_ser);
    end
    bus.in_valid = 1'b0;
    bp_hold = 1'b0;
    send(3'b010, 1, 8'h02, 16'h0000, 8'h01, 1'b0);

    // Reset in the middle of a rotate: discarded, no result.
    wait_ready(ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.op       = 3'b100;
      bus.amount   = SHAMT_W'(6);
      bus.data_in  = 8'h0F;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_data_out", bus.data_out, 0);
      check("midrst_ser_out", bus.ser_out, 0);
      repeat (8) @(posedge clk);
    end
    send(3'b001, 2, 8'h01, 16'h0000, 8'h04, 1'b0);

    // Randomized traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) send_rand();

    waited = 0;
    while (sb.size() > 0 && waited < 300) begin @(negedge clk); waited++; end
    check("drain_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
